// File: rtl/ff_sig_pkg.sv
// Shared definitions for the flip-flop signature sink: FSM state encoding
// and the Galois MISR next-state function used by the MISR register.
package ff_sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ff_sig_state_e;

  localparam int MAX_WIDTH = 32;

  // One Galois MISR step on a register of 'width' bits (held in the low bits
  // of a 32-bit word): shift left, fold the MSB back through poly, inject sin
  // with sin[0] landing on bit 0.
  function automatic logic [MAX_WIDTH-1:0] misr_next(
    input logic [MAX_WIDTH-1:0] sig,
    input logic [3:0]           sin,
    input logic [MAX_WIDTH-1:0] poly,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] shifted;
    logic                 fb;
    mask    = (width >= MAX_WIDTH) ? {MAX_WIDTH{1'b1}}
                                   : ((32'd1 << width) - 32'd1);
    fb      = sig[5'(width - 1)];
    shifted = (sig << 1) & mask;
    misr_next = shifted ^ (fb ? (poly & mask) : '0) ^ {28'd0, sin};
  endfunction

endpackage

// File: rtl/ff_sig_misr.sv
// WIDTH-bit multiple-input signature register with synchronous load of SEED
// and a per-cycle update enable. Also exposes the combinational next value so
// the controller can judge the final signature without waiting a cycle.
module ff_sig_misr
  import ff_sig_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h002D,
  parameter logic [WIDTH-1:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [3:0]       sin,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  logic [MAX_WIDTH-1:0] nxt_full;

  // Next MISR value for the current contents and input sample.
  always_comb begin
    nxt_full = misr_next(MAX_WIDTH'(sig), sin, MAX_WIDTH'(POLY), WIDTH);
  end

  assign sig_next = nxt_full[WIDTH-1:0];

  generate
    if (WIDTH < MAX_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^nxt_full[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

  // Signature register: reset and load both return to SEED; load wins over en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/ff_signature_sink.sv
// Signature sink for the flop-mode pack test block. Samples {outd..outa} on
// rising clk while cen=1, folds COUNT samples into a MISR and then holds a
// stable signature with done=1.
//
// Handshake: start is level-sampled in IDLE/DONE; the cycle it is seen only
// reloads SEED and clears cnt, sampling begins the following cycle. While
// busy=1, start is ignored. done stays high until the next accepted start.
//
// Optional macro FF_SIGNATURE_SINK_GOLDEN_CHECK_EN adds a registered 'pass'
// output comparing the final signature against GOLDEN.
module ff_signature_sink
  import ff_sig_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'h002D,
  parameter logic [WIDTH-1:0] SEED   = 16'hFFFF,
  parameter int               COUNT  = 256,
  parameter logic [WIDTH-1:0] GOLDEN = 16'h0000,
  localparam int              CW     = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cen,
  input  logic [3:0]       sin,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cnt,
`ifdef FF_SIGNATURE_SINK_GOLDEN_CHECK_EN
  output logic             pass,
`endif
  output logic [WIDTH-1:0] signature
);

  localparam logic [CW-1:0] COUNT_V = CW'(COUNT);

  ff_sig_state_e  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic           misr_load, misr_en;
  logic [WIDTH-1:0] sig_next;

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state, counter and MISR control decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          misr_load = 1'b1;
        end
      end
      RUN: begin
        if (cen) begin
          misr_en = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == COUNT_V) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  assign cnt = cnt_q;

  ff_sig_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (misr_load),
    .en       (misr_en),
    .sin      (sin),
    .sig      (signature),
    .sig_next (sig_next)
  );

`ifdef FF_SIGNATURE_SINK_GOLDEN_CHECK_EN
  // Golden verdict: judged on the final update, cleared by every new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass <= 1'b0;
    end else if (misr_load) begin
      pass <= 1'b0;
    end else if ((state_q == RUN) && (state_d == DONE)) begin
      pass <= (sig_next == GOLDEN);
    end
  end
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
`endif

endmodule

// File: doc/ff_signature_sink.md
# ff_signature_sink

Downstream compaction stage for the flip-flop-mode pack test designs. It samples the four registered outputs of the flop-mode test block (outa..outd) on rising clk edges. It folds them into a multiple-input signature register (MISR) for a programmed number of enabled cycles and then presents a stable signature. This reduces four toggling nets to one comparable word, so packer/placer regressions on the upstream flops show up as a signature mismatch.

## Interface
- WIDTH, 16: MISR width; legal range 4..32.
- POLY, 16'h002D: Galois feedback polynomial, WIDTH bits, x^WIDTH term implicit.
- SEED, 16'hFFFF: MISR value loaded on reset and on every accepted start.
- COUNT, 256: number of enabled samples per run; legal range 1..65535.
- GOLDEN, 16'h0000: expected signature (used only with the Configuration macro).

Ports:
- clk, input, 1: sample clock; same net that clocks the upstream flops.
- rst, input, 1: reset; asynchronous, active-high.
- start, input, 1: begin a run; level-sampled.
- cen, input, 1: sample enable; a sample is taken only in cycles where cen=1.
- sin, input, 4: {outd, outc, outb, outa} from the upstream block.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.
- cnt, output, $clog2(COUNT+1): samples taken in the current run.
- signature, output, WIDTH: current MISR contents.

## Operation
- Reset (async, rst=1): state=IDLE, signature=SEED, cnt=0, busy=0, done=0 (and pass=0 when the macro is defined).
- States:
  - IDLE: if start=1, go to RUN, load signature=SEED, set cnt=0. No sample is taken in that cycle.
  - RUN: each cycle with cen=1 performs a MISR update and cnt+1. When the update makes cnt reach COUNT, go to DONE. Cycles with cen=0 hold everything. start is ignored.
  - DONE: signature and cnt hold. If start=1, go to RUN with the same reload as from IDLE.
- MISR update:
  - fb = signature[WIDTH-1].
  - next = (signature << 1, truncated to WIDTH) XOR (fb ? POLY : 0) XOR zero-extended sin.
  - sin[0] aligns with signature bit 0.
- sin is sampled at posedge clk only. The negedge-clocked upstream outputs are stable at posedge and need no extra capture.
- cnt never exceeds COUNT and never wraps.
- rst asserted mid-run aborts immediately to the reset values. Partial signature is discarded.
- start and cen both high in the cycle a run begins: only the reload happens; sampling starts next cycle.

## Timing
- The MISR update is visible on signature one cycle after the sampled edge.
- done rises in the same cycle that the COUNT-th update becomes visible.
- Minimum run length is COUNT+1 cycles from start to done, with cen held high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: FF_SIGNATURE_SINK_GOLDEN_CHECK_EN.
- Defined:
  - Adds output port pass (input/output direction: output, width 1).
  - pass is registered: it is set to (next signature == GOLDEN) on the RUN->DONE transition.
  - pass is cleared on reset and on every accepted start, and holds in DONE.
- Undefined: no pass port; GOLDEN is unused; behaviour is otherwise identical.

## Structure
- Shared package ff_sig_pkg holds:
  - the state enum IDLE/RUN/DONE;
  - a function misr_next(sig, sin, POLY).
- One natural sub-module, ff_sig_misr: the WIDTH-bit register with load/enable, instantiated once.
- FSM and counter stay in the top module.

## Test plan
- Reset then idle: rst pulse with start=0 → signature=16'hFFFF, cnt=0, busy=0, done=0, held for 10 cycles.
- Single step: COUNT=1, SEED=16'h0001, start, then sin=4'h0 with cen=1 → signature=16'h0002, done=1 one cycle after the sample.
- Feedback: COUNT=1, SEED=16'h8000, sin=4'h0 → signature=16'h002D.
- Input injection: COUNT=1, SEED=16'h0000, sin=4'hF → signature=16'h000F.
- Enable gating: COUNT=4, with cen toggling 1,0,1,0,1,0,1 → done asserts only after the 4th cen=1 cycle, and cnt steps 1..4.
- Abort and restart: rst asserted when cnt=100 of 256 → immediate IDLE/SEED. A fresh start with identical stimulus reproduces the same final signature as an uninterrupted run. With the macro defined and GOLDEN set to that value, pass=1; with GOLDEN+1, pass=0.
